// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - write/commit port and display outputs of the segment scan controller
// blink_mask is present only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 8
);
    logic                  wr_en;
    logic [3:0]            wr_addr;
    logic [7:0]            wr_code;
    logic                  commit;
    logic                  blank;
`ifdef SEG_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_mask;
`endif
    logic                  commit_busy;
    logic                  commit_done;
    logic [7:0]            digit_code;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  frame_tick;

`ifdef SEG_SCAN_BLINK_EN
    modport master (
        output wr_en, wr_addr, wr_code, commit, blank, blink_mask,
        input  commit_busy, commit_done, digit_code, digit_sel, frame_tick
    );
    modport slave (
        input  wr_en, wr_addr, wr_code, commit, blank, blink_mask,
        output commit_busy, commit_done, digit_code, digit_sel, frame_tick
    );
`else
    modport master (
        output wr_en, wr_addr, wr_code, commit, blank,
        input  commit_busy, commit_done, digit_code, digit_sel, frame_tick
    );
    modport slave (
        input  wr_en, wr_addr, wr_code, commit, blank,
        output commit_busy, commit_done, digit_code, digit_sel, frame_tick
    );
`endif
endinterface

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - time-multiplexed seven-segment scan controller with double-buffered codes
// Optional per-digit blinking is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_controller #(
    parameter int          NUM_DIGITS   = 8,
    parameter int          SCAN_DIV     = 1000,
    parameter int          GUARD_CYC    = 4,
    parameter logic [7:0]  BLANK_CODE   = 8'd34
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int          BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_controller_if.slave  bus
);
    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] ON_LAST    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            shadow_q [NUM_DIGITS];
    logic [7:0]            shadow_d [NUM_DIGITS];
    logic [7:0]            active_q [NUM_DIGITS];
    logic [7:0]            active_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [7:0]            digit_code_q, digit_code_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  commit_busy_q, commit_busy_d;
    logic                  commit_done_q, commit_done_d;
    logic                  bnd_next;
    logic                  pending;
    logic                  hide;

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        if (state_q == ST_GUARD) begin
            if (cnt_q == GUARD_LAST) begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        end else if (cnt_q == ON_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        bnd_next      = (state_d == ST_ON) && (idx_d == IDX_LAST) && (cnt_d == ON_LAST);
        pending       = commit_busy_q | bus.commit;
        frame_tick_d  = bnd_next;
        commit_done_d = bnd_next & pending;
        commit_busy_d = pending & ~bnd_next;

        hide = bus.blank;
`ifdef SEG_SCAN_BLINK_EN
        hide = hide | (blink_phase_q & bus.blink_mask[idx_d]);
`endif
        digit_sel_d  = '0;
        digit_code_d = BLANK_CODE;
        if (state_d == ST_ON) begin
            digit_sel_d = NUM_DIGITS'(1) << idx_d;
            if (!hide) begin
                digit_code_d = active_q[idx_d];
            end
        end
    end

    // The copy happens at the end of the frame-boundary cycle, so a write in that cycle is not copied.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.wr_en && (32'(bus.wr_addr) == i)) begin
                shadow_d[i] = bus.wr_code;
            end
        end
        if (commit_done_q) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_GUARD;
            cnt_q         <= '0;
            idx_q         <= '0;
            digit_sel_q   <= '0;
            digit_code_q  <= BLANK_CODE;
            frame_tick_q  <= 1'b0;
            commit_busy_q <= 1'b0;
            commit_done_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= BLANK_CODE;
                active_q[i] <= BLANK_CODE;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            digit_sel_q   <= digit_sel_d;
            digit_code_q  <= digit_code_d;
            frame_tick_q  <= frame_tick_d;
            commit_busy_q <= commit_busy_d;
            commit_done_q <= commit_done_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    assign bus.digit_sel   = digit_sel_q;
    assign bus.digit_code  = digit_code_q;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.commit_busy = commit_busy_q;
    assign bus.commit_done = commit_done_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - directed timeline bench for seg_scan_controller (4 digits, SCAN_DIV 4, GUARD 1)
module tb_seg_scan_controller;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_scan_controller_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_controller #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .GUARD_CYC  (1),
        .BLANK_CODE (8'd34)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic       rst;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [7:0] wr_code;
        logic       commit;
        logic       blank;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [7:0] code;
        logic       tick;
        logic       busy;
        logic       done;
        string      name;
    } chk_t;

    stim_t stims[$];
    chk_t  chks[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic add_s(input int c, input logic r, input logic we, input int a, input int code,
                         input logic cm, input logic bl);
        stims.push_back('{c, r, we, 4'(a), 8'(code), cm, bl});
    endtask

    task automatic add_c(input int c, input logic [3:0] s, input int code, input logic t,
                         input logic b, input logic d, input string n);
        chks.push_back('{c, s, 8'(code), t, b, d, n});
    endtask

    initial begin
        // Stimulus timeline: cycle 0 is the first cycle after reset release.
        add_s( 21, 0, 1, 0, 1, 0, 0);
        add_s( 22, 0, 1, 1, 2, 0, 0);
        add_s( 23, 0, 1, 2, 3, 0, 0);
        add_s( 24, 0, 1, 3, 4, 0, 0);
        add_s( 25, 0, 0, 0, 0, 1, 0);
        add_s( 61, 0, 1, 2, 9, 0, 0);
        add_s( 66, 0, 0, 0, 0, 0, 1);
        add_s( 67, 0, 0, 0, 0, 0, 1);
        add_s(112, 0, 0, 0, 0, 1, 0);
        add_s(140, 0, 1, 5, 7, 0, 0);
        add_s(141, 0, 0, 0, 0, 1, 0);
        add_s(159, 0, 1, 0, 8, 0, 0);
        add_s(182, 0, 0, 0, 0, 1, 0);
        add_s(218, 0, 1, 1, 5, 0, 0);
        add_s(219, 0, 0, 0, 0, 1, 0);
        add_s(225, 0, 0, 0, 0, 1, 0);
        add_s(250, 0, 0, 0, 0, 1, 0);
        add_s(252, 1, 0, 0, 0, 0, 0);

        add_c(  0, 4'b0000, 34, 0, 0, 0, "reset_state");
        add_c(  1, 4'b0001, 34, 0, 0, 0, "d0_first_on");
        add_c(  4, 4'b0001, 34, 0, 0, 0, "d0_last_on");
        add_c(  5, 4'b0000, 34, 0, 0, 0, "guard_d1");
        add_c(  6, 4'b0010, 34, 0, 0, 0, "d1_first_on");
        add_c(  9, 4'b0010, 34, 0, 0, 0, "d1_last_on");
        add_c( 16, 4'b1000, 34, 0, 0, 0, "d3_on");
        add_c( 18, 4'b1000, 34, 0, 0, 0, "no_early_tick");
        add_c( 19, 4'b1000, 34, 1, 0, 0, "first_frame_tick");
        add_c( 20, 4'b0000, 34, 0, 0, 0, "tick_one_cycle");
        add_c( 26, 4'b0010, 34, 0, 1, 0, "busy_set");
        add_c( 38, 4'b1000, 34, 0, 1, 0, "busy_held");
        add_c( 39, 4'b1000, 34, 1, 0, 1, "commit_done_at_tick");
        add_c( 40, 4'b0000, 34, 0, 0, 0, "done_one_cycle");
        add_c( 41, 4'b0001,  1, 0, 0, 0, "frame2_d0");
        add_c( 46, 4'b0010,  2, 0, 0, 0, "frame2_d1");
        add_c( 51, 4'b0100,  3, 0, 0, 0, "frame2_d2");
        add_c( 56, 4'b1000,  4, 0, 0, 0, "frame2_d3");
        add_c( 59, 4'b1000,  4, 1, 0, 0, "frame2_tick");
        add_c( 66, 4'b0010,  2, 0, 0, 0, "blank_latency");
        add_c( 67, 4'b0010, 34, 0, 0, 0, "blank_on");
        add_c( 68, 4'b0010, 34, 0, 0, 0, "blank_held");
        add_c( 69, 4'b0010,  2, 0, 0, 0, "blank_off");
        add_c( 71, 4'b0100,  3, 0, 0, 0, "no_commit_f3");
        add_c(111, 4'b0100,  3, 0, 0, 0, "no_commit_f5");
        add_c(113, 4'b0100,  3, 0, 1, 0, "busy_f5");
        add_c(119, 4'b1000,  4, 1, 0, 1, "done_f5");
        add_c(126, 4'b0010,  2, 0, 0, 0, "f6_d1");
        add_c(131, 4'b0100,  9, 0, 0, 0, "f6_d2_new");
        add_c(159, 4'b1000,  4, 1, 0, 1, "done_f7");
        add_c(161, 4'b0001,  1, 0, 0, 0, "copy_cycle_write_old");
        add_c(166, 4'b0010,  2, 0, 0, 0, "bad_addr_d1");
        add_c(171, 4'b0100,  9, 0, 0, 0, "bad_addr_d2");
        add_c(176, 4'b1000,  4, 0, 0, 0, "bad_addr_d3");
        add_c(181, 4'b0001,  1, 0, 0, 0, "still_old_f9");
        add_c(199, 4'b1000,  4, 1, 0, 1, "done_f9");
        add_c(201, 4'b0001,  8, 0, 0, 0, "late_commit_new");
        add_c(219, 4'b1000,  4, 1, 0, 0, "commit_on_bnd_no_done");
        add_c(220, 4'b0000, 34, 0, 1, 0, "commit_on_bnd_busy");
        add_c(226, 4'b0010,  2, 0, 1, 0, "commit_on_bnd_not_copied");
        add_c(239, 4'b1000,  4, 1, 0, 1, "single_done");
        add_c(240, 4'b0000, 34, 0, 0, 0, "no_second_busy");
        add_c(246, 4'b0010,  5, 0, 0, 0, "bnd_commit_copied");
        add_c(252, 4'b0100,  9, 0, 1, 0, "pre_reset");
        add_c(253, 4'b0000, 34, 0, 0, 0, "reset_mid_frame");
        add_c(254, 4'b0001, 34, 0, 0, 0, "restart_d0");
        add_c(259, 4'b0010, 34, 0, 0, 0, "restart_d1");
        add_c(272, 4'b1000, 34, 1, 0, 0, "post_reset_tick_no_done");

        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_code = '0;
        bus.commit  = 1'b0;
        bus.blank   = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        bus.blink_mask = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc <= 275; cyc++) begin
            foreach (chks[k]) begin
                if (chks[k].cyc == cyc) begin
                    n_vec++;
                    if (bus.digit_sel !== chks[k].sel || bus.digit_code !== chks[k].code ||
                        bus.frame_tick !== chks[k].tick || bus.commit_busy !== chks[k].busy ||
                        bus.commit_done !== chks[k].done) begin
                        n_bad++;
                        $display("FAIL %s cyc=%0d got sel=%b code=%0d tick=%b busy=%b done=%b want sel=%b code=%0d tick=%b busy=%b done=%b",
                                 chks[k].name, cyc, bus.digit_sel, bus.digit_code, bus.frame_tick,
                                 bus.commit_busy, bus.commit_done, chks[k].sel, chks[k].code,
                                 chks[k].tick, chks[k].busy, chks[k].done);
                    end
                end
            end
            n_vec++;
            if ($countones(bus.digit_sel) > 1) begin
                n_bad++;
                $display("FAIL onehot cyc=%0d got sel=%b want at most one bit set", cyc, bus.digit_sel);
            end

            rst_n       = 1'b1;
            bus.wr_en   = 1'b0;
            bus.wr_addr = '0;
            bus.wr_code = '0;
            bus.commit  = 1'b0;
            bus.blank   = 1'b0;
            foreach (stims[k]) begin
                if (stims[k].cyc == cyc) begin
                    rst_n       = ~stims[k].rst;
                    bus.wr_en   = stims[k].wr_en;
                    bus.wr_addr = stims[k].wr_addr;
                    bus.wr_code = stims[k].wr_code;
                    bus.commit  = stims[k].commit;
                    bus.blank   = stims[k].blank;
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scan controller for the multi-digit seven-segment display.
- Holds one character code per digit in a double-buffered register bank and sequences the digits one at a time. For each digit it presents that digit's code to the shared code-to-segment decoder and drives the matching one-hot digit enable.
- Guard intervals between digits prevent ghosting.
- Game logic writes codes through a simple write port and commits a whole frame atomically.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16)
- SCAN_DIV, 1000, clock cycles each digit is enabled (>=1)
- GUARD_CYC, 4, clock cycles all digits are off before each digit (>=1)
- BLANK_CODE, 34, character code the decoder renders as all segments off

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write shadow entry this cycle
- wr_addr  in  4  digit index to write; indices >= NUM_DIGITS are ignored
- wr_code  in  8  character code (0..36) written to the shadow entry
- commit  in  1  one-cycle request to copy the shadow bank to the active bank at the next frame boundary
- blank  in  1  level; forces every displayed digit to BLANK_CODE
- commit_busy  out  1  high while a commit is pending
- commit_done  out  1  one-cycle pulse when the active bank has been updated
- digit_code  out  8  code for the currently enabled digit; feeds the decoder
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active high; all zero during guard
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clocking and reset: single clock domain, clk. Reset is synchronous and active-low on rst_n; all state updates on the rising edge of clk.
- Reset values (rst_n low at the edge):
  - shadow and active entries = BLANK_CODE
  - digit index = 0; FSM in GUARD with cycle counter 0
  - digit_sel = 0; digit_code = BLANK_CODE
  - frame_tick, commit_busy and commit_done = 0
- Reset mid-frame or mid-commit discards the pending commit and restarts scanning at digit 0.
- FSM has two states:
  - GUARD: digit_sel = 0, digit_code = BLANK_CODE. Stays for GUARD_CYC cycles, then goes to ON.
  - ON: digit_sel = one-hot(idx). digit_code = active[idx], or BLANK_CODE when blank is high. Stays for SCAN_DIV cycles, then goes to GUARD with idx advanced.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame length is NUM_DIGITS*(GUARD_CYC+SCAN_DIV) cycles. The first ON cycle of digit 0 after reset is cycle GUARD_CYC.
- All outputs are registered; the blank input affects digit_code one cycle after it changes.
- Frame boundary is the ON->GUARD transition leaving idx NUM_DIGITS-1. On that cycle:
  - frame_tick pulses.
  - If a commit is pending: active <= shadow, commit_busy clears, and commit_done pulses in the same cycle as frame_tick.
- Writes:
  - wr_en with wr_addr < NUM_DIGITS updates the shadow entry next edge; other addresses have no effect.
  - Writes never touch the active bank directly.
- Simultaneous events:
  - Write on the copy cycle: active receives the pre-write shadow value; shadow keeps the new value, which appears only after a later commit.
  - commit while busy: no additional effect; a single copy occurs.
  - commit on the frame-boundary cycle: becomes pending for the following boundary; it is not copied in the same cycle.
- Counter widths use $clog2 of SCAN_DIV, GUARD_CYC and NUM_DIGITS.
- digit_sel has at most one bit set in every cycle.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask[NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles a blink phase bit every BLINK_FRAMES frame_ticks; the phase is 0 after reset.
  - While phase = 1, digits whose mask bit is set show BLANK_CODE during ON; digit_sel is unchanged.
- Undefined: no blink_mask port, no frame counter, behaviour exactly as above.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1, BLANK_CODE=34):
- Release reset, no writes -> digit_sel = 0001 on cycles 1-4, 0000 on cycle 5, 0010 on cycles 6-9; digit_code = 34 throughout; frame_tick on cycle 19 only within the first frame, then every 20 cycles.
- Write codes 1,2,3,4 to addresses 0-3, pulse commit -> commit_busy high until the next boundary; commit_done coincides with frame_tick; the next frame shows digit_code 1,2,3,4 under digit_sel 0001,0010,0100,1000.
- Write address 2 = 9 without commit -> display unchanged for 3 frames; after commit the next frame shows 9 on digit 2.
- Assert blank during digit 1's ON window -> digit_code = 34 from the next cycle; digit_sel still 0010; deassert -> the code returns.
- Write addr 5 = 7, then commit -> all active entries unchanged; write on the copy cycle to addr 0 = 8 -> the old value is displayed, and 8 appears only after a later commit.
- Assert rst_n low in the middle of digit 2 with a commit pending -> next cycle digit_sel = 0, digit_code = 34, commit_busy = 0; scanning restarts at digit 0.
